// File: rtl/uart_tx_wrapper.sv
// ---------------------------------------------------------------------------
// uart_tx_wrapper
//
// Byte-stream to 8N1 serial transmitter with a small input FIFO.
// Bytes arrive on a valid/ready handshake (rd_avl / rd_rdy). They are queued
// in a power-of-two FIFO and sent LSB first as 1 start bit, 8 data bits and
// 1 stop bit. Each bit lasts CLKS_PER_BIT clocks. Queued frames follow each
// other back-to-back, with no idle bit between them.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per serial bit (1..65535)
//   FIFO_DEPTH   : byte entries in the input FIFO (power of two, 2..64)
//
// Ports
//   clk      in   1  sole clock, all state updates on posedge
//   rst      in   1  asynchronous active-high reset
//   rd_avl   in   1  upstream presents a byte on rd_data
//   rd_data  in   8  byte to transmit
//   rd_rdy   out  1  a byte is accepted on this cycle's edge if rd_avl=1
//   txd      out  1  registered serial line, idle high
//   busy     out  1  a frame is in flight or the FIFO holds data
// ---------------------------------------------------------------------------
module uart_tx_wrapper #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rd_avl,
    input  logic [7:0] rd_data,
    output logic       rd_rdy,
    output logic       txd,
    output logic       busy
);

    // -----------------------------------------------------------------------
    // Sizing
    // -----------------------------------------------------------------------
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;              // holds 0..FIFO_DEPTH
    // A one-clock bit still needs a one-bit counter to keep widths legal.
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // -----------------------------------------------------------------------
    // FIFO storage and control
    // -----------------------------------------------------------------------
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // -----------------------------------------------------------------------
    // Transmitter state
    // -----------------------------------------------------------------------
    state_t            r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_txd;

    logic w_push;
    logic w_pop;
    logic w_fifo_empty;
    logic w_baud_done;

    // Ready comes straight from the registered count. It is forced low while
    // reset is held, so no byte can be accepted during reset.
    assign rd_rdy       = ~rst & (r_count != CNT_FULL);
    assign w_push       = rd_avl & rd_rdy;
    assign w_fifo_empty = (r_count == '0);
    assign w_baud_done  = (r_baud == BAUD_LAST);

    // The transmitter takes a byte in two places: from IDLE as soon as data
    // is present, and at the final clock of a stop bit. Taking it at the end
    // of the stop bit chains frames with no idle gap.
    assign w_pop = ~w_fifo_empty &
                   ((r_state == S_IDLE) |
                    ((r_state == S_STOP) & w_baud_done));

    // Storage has no reset. A write needs w_push, and w_push is already
    // gated off during reset, so stale contents are never read: the count
    // is cleared by reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rd_data;
        end
    end

    // Pointer and occupancy bookkeeping. The pointers wrap naturally because
    // the depth is a power of two. A push while full is blocked by rd_rdy. A
    // pop while empty is blocked inside w_pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Frame sequencer
    //
    // txd is registered and loaded with the level for the coming clock
    // period. When a state changes, the new state's line level goes out on
    // that same edge, so each bit is exactly CLKS_PER_BIT clocks wide and a
    // frame is exactly 10*CLKS_PER_BIT clocks long.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_txd     <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_txd  <= 1'b1;
                    r_baud <= '0;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_state <= S_START;
                        r_txd   <= 1'b0;
                    end
                end

                S_START: begin
                    if (w_baud_done) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                        r_txd     <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end

                S_DATA: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_shift <= r_shift >> 1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                            r_txd   <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            // bit 1 is what lands in bit 0 after this shift
                            r_txd     <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end

                S_STOP: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift <= r_mem[r_rd_ptr];
                            r_state <= S_START;
                            r_txd   <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_txd   <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_baud  <= '0;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

    assign txd  = r_txd;
    assign busy = (r_state != S_IDLE) | ~w_fifo_empty;

endmodule

// File: tb/tb_uart_tx_wrapper.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_wrapper
//
// Checks uart_tx_wrapper against a frame-timing reference model. The model
// tracks accepted bytes in a queue. It derives the serial line level from
// the clock count since the current frame began. A second instance with
// one-clock bits feeds a small serial decoder.
// ---------------------------------------------------------------------------
module tb_uart_tx_wrapper;

    localparam int C  = 16;
    localparam int D  = 4;
    localparam int C1 = 1;
    localparam int D1 = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       rd_avl;
    logic [7:0] rd_data;
    logic       rd_rdy;
    logic       txd;
    logic       busy;

    logic       rd_avl1;
    logic [7:0] rd_data1;
    logic       rd_rdy1;
    logic       txd1;
    logic       busy1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_wrapper #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .rd_avl  (rd_avl),
        .rd_data (rd_data),
        .rd_rdy  (rd_rdy),
        .txd     (txd),
        .busy    (busy)
    );

    uart_tx_wrapper #(.CLKS_PER_BIT(C1), .FIFO_DEPTH(D1)) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .rd_avl  (rd_avl1),
        .rd_data (rd_data1),
        .rd_rdy  (rd_rdy1),
        .txd     (txd1),
        .busy    (busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model: a queue of waiting bytes plus the edge number at
    // which the current frame's start bit went out.
    // -----------------------------------------------------------------------
    logic [7:0] q[$];
    bit         m_active = 1'b0;
    logic [7:0] m_byte   = 8'h00;
    int         m_ecount = 0;
    int         m_fstart = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_active = 1'b0;
        end else begin
            bit do_push;
            bit do_pop;
            m_ecount++;
            if (m_active && (m_ecount - m_fstart == 10 * C)) begin
                m_active = 1'b0;
            end
            do_push = rd_avl && (q.size() != D);
            do_pop  = !m_active && (q.size() != 0);
            if (do_pop) begin
                m_byte   = q.pop_front();
                m_active = 1'b1;
                m_fstart = m_ecount;
            end
            if (do_push) begin
                q.push_back(rd_data);
            end
        end
    end

    function automatic logic exp_txd();
        int k;
        if (!m_active) return 1'b1;
        k = (m_ecount - m_fstart) / C;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_byte[k-1];
        return 1'b1;
    endfunction

    // One compare per output per cycle, away from the active edge.
    always @(negedge clk) begin
        chk("txd",    txd,    exp_txd());
        chk("busy",   busy,   (m_active || q.size() != 0));
        chk("rd_rdy", rd_rdy, (!rst && q.size() != D));
    end

    // -----------------------------------------------------------------------
    // Serial decoder for the one-clock-per-bit instance
    // -----------------------------------------------------------------------
    logic [7:0] rx_q[$];
    logic [7:0] rx_sh  = 8'h00;
    int         rx_n   = 0;
    int         rx_err = 0;

    always @(negedge clk) begin
        if (rst) begin
            rx_n = 0;
        end else if (rx_n == 0) begin
            if (txd1 == 1'b0) rx_n = 1;
        end else if (rx_n <= 8) begin
            rx_sh[rx_n-1] = txd1;
            rx_n++;
        end else begin
            if (txd1 !== 1'b1) rx_err++;
            rx_q.push_back(rx_sh);
            rx_n = 0;
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] pat55;
        int n_acc;
        int guard;
        pat55 = 10'h2AA;  // start, 1,0,1,0,1,0,1,0, stop

        rst = 1'b1; rd_avl = 1'b0; rd_data = 8'h00; rd_avl1 = 1'b0; rd_data1 = 8'h00;
        repeat (3) step();
        chk("rst_txd",  txd,    1'b1);
        chk("rst_rdy",  rd_rdy, 1'b0);
        chk("rst_busy", busy,   1'b0);
        #1 rst = 1'b0;
        #1 chk("rdy_after_rst", rd_rdy, 1'b1);

        // Single 0x55 frame, sampled mid-bit
        step(); rd_avl = 1'b1; rd_data = 8'h55;
        step(); rd_avl = 1'b0; rd_data = 8'hC3;
        repeat (9) step();
        for (int k = 0; k < 10; k++) begin
            chk("f55_txd", txd, pat55[k]);
            chk("f55_model", exp_txd(), pat55[k]);
            if (k < 9) repeat (16) step();
        end
        repeat (7) step();
        chk("f55_busy_last", busy, 1'b1);
        step();
        chk("f55_busy_fall", busy, 1'b0);

        // Four back-to-back bytes
        step(); rd_avl = 1'b1; rd_data = 8'h01;
        step(); rd_data = 8'h80;
        step(); rd_data = 8'hFF;
        step(); rd_data = 8'h00;
        step(); rd_avl = 1'b0;
        repeat (166) step();
        chk("f4_second_start", txd, 1'b0);
        repeat (128) step();
        chk("f4_80_bit7", txd, 1'b1);
        repeat (343) step();
        chk("f4_busy_last", busy, 1'b1);
        step();
        chk("f4_busy_fall", busy, 1'b0);

        // Fill with rd_avl held high
        step(); rd_avl = 1'b1; rd_data = 8'($urandom);
        n_acc = 0; guard = 0;
        while (rd_rdy && guard < 20) begin
            n_acc++;
            step(); rd_data = 8'($urandom);
            guard++;
        end
        chk("fill_accepted", n_acc, 5);
        repeat (156) step();
        chk("fill_rdy_before_stop_end", rd_rdy, 1'b0);
        step();
        chk("fill_rdy_after_stop_end", rd_rdy, 1'b1);
        step();
        chk("fill_rdy_refilled", rd_rdy, 1'b0);
        rd_avl = 1'b0;
        guard = 0;
        while (busy && guard < 1200) begin step(); guard++; end
        chk("fill_drain", busy, 1'b0);

        // Reset during DATA bit 3 of 0xA5 with two bytes queued
        step(); rd_avl = 1'b1; rd_data = 8'hA5;
        step(); rd_data = 8'h11;
        step(); rd_data = 8'h22;
        step(); rd_avl = 1'b0;
        repeat (71) step();
        chk("a5_bit3", txd, 1'b0);
        rst = 1'b1;
        #1;
        chk("abort_txd",  txd,    1'b1);
        chk("abort_busy", busy,   1'b0);
        chk("abort_rdy",  rd_rdy, 1'b0);
        repeat (2) step();
        #1 rst = 1'b0;
        repeat (50) step();
        chk("abort_quiet_busy", busy, 1'b0);
        chk("abort_quiet_txd",  txd,  1'b1);
        step(); rd_avl = 1'b1; rd_data = 8'h3C;
        step(); rd_avl = 1'b0;
        repeat (170) step();
        chk("abort_single_frame", busy, 1'b0);

        // One clock per bit, decoded serially
        rx_q.delete(); rx_err = 0;
        step(); rd_avl1 = 1'b1; rd_data1 = 8'hA3;
        step(); rd_data1 = 8'h0D;
        step(); rd_avl1 = 1'b0;
        repeat (30) step();
        chk("c1_count", rx_q.size(), 2);
        chk("c1_byte0", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'hA3);
        chk("c1_byte1", (rx_q.size() > 1) ? rx_q[1] : 8'hxx, 8'h0D);
        chk("c1_stop_err", rx_err, 0);
        chk("c1_busy", busy1, 1'b0);
        chk("c1_rdy",  rd_rdy1, 1'b1);

        // Random traffic with varying load and rare resets
        for (int seg = 0; seg < 6; seg++) begin
            int p;
            case (seg)
                0: p = 95;
                1: p = 3;
                2: p = 50;
                3: p = 100;
                4: p = 10;
                default: p = 70;
            endcase
            for (int i = 0; i < 800; i++) begin
                step();
                rd_avl  = ($urandom_range(0, 99) < p);
                rd_data = 8'($urandom);
                if ($urandom_range(0, 999) == 0) begin
                    rst = 1'b1;
                    step();
                    #1 rst = 1'b0;
                end
            end
        end
        step(); rd_avl = 1'b0;
        guard = 0;
        while (busy && guard < 1200) begin step(); guard++; end
        chk("rand_drain", busy, 1'b0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_wrapper.md
UART_TX_WRAPPER -- requirements
Module: uart_tx_wrapper

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit (legal range 1..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning byte entries in the input FIFO (power of two, 2..64).
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port: clk  input  1  sole clock; all state updates on posedge.
REQ-005 SHALL have port: rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port: rd_avl  input  1  upstream has a byte on rd_data.
REQ-007 SHALL have port: rd_data  input  8  byte to transmit.
REQ-008 SHALL have port: rd_rdy  output  1  block can accept a byte this cycle.
REQ-009 SHALL have port: txd  output  1  serial line, 8N1, idle high, registered.
REQ-010 SHALL have port: busy  output  1  high while a frame is in flight or the FIFO is non-empty.

Function
REQ-011 SHALL transfer a byte into the FIFO on a posedge where rd_avl=1 and rd_rdy=1; no transfer otherwise.
REQ-012 SHALL drive rd_rdy = ~rst AND (fifo count != FIFO_DEPTH), combinationally from registered count.
REQ-013 SHALL keep the count unchanged on a cycle with both a push and a pop; a push can never occur when full, and a pop never occurs when empty.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP with a baud counter (0..CLKS_PER_BIT-1) and a bit index (0..7).
REQ-015 IDLE: txd=1; if the FIFO is non-empty, pop the head into an 8-bit shift register, clear the baud counter, go to START.
REQ-016 START: txd=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-017 DATA: txd=shift register bit 0 (LSB first) for CLKS_PER_BIT cycles per bit; shift right at each bit end; after bit 7 go to STOP.
REQ-018 STOP: txd=1 for exactly CLKS_PER_BIT cycles; at its end, if the FIFO is non-empty, pop and go directly to START (no idle bit), else go to IDLE.
REQ-019 SHALL make a frame exactly 10*CLKS_PER_BIT cycles long.
REQ-020 With the FSM in IDLE and the FIFO empty, a byte pushed at edge N SHALL be popped at edge N+1, with txd low from edge N+1 onward.
REQ-021 SHALL register txd from next-state logic; txd shall never glitch between edges.
REQ-022 SHALL drive busy = (state != IDLE) OR (fifo count != 0).
REQ-023 SHALL wrap the FIFO read/write pointers modulo FIFO_DEPTH; the count width holds 0..FIFO_DEPTH inclusive.
REQ-024 Changes to rd_data while rd_rdy=0 or rd_avl=0 SHALL have no effect.

Reset
REQ-025 While rst=1: txd=1, rd_rdy=0, busy=0, state=IDLE, FIFO count=0, pointers=0, baud counter=0, bit index=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately (txd=1 asynchronously) and discard all FIFO contents.
REQ-027 On the first posedge after rst deasserts, rd_rdy=1 and the block SHALL accept a byte.

Verification
REQ-028 Single byte 0x55, CLKS_PER_BIT=16 -> txd after pop: 0 (start), then 1,0,1,0,1,0,1,0, then 1 (stop), each 16 cycles; 160 cycles total; busy falls after the stop bit.
REQ-029 Four bytes 0x01,0x80,0xFF,0x00 pushed back-to-back -> four contiguous 160-cycle frames, no idle gap, LSB-first contents match.
REQ-030 FIFO_DEPTH=4, rd_avl held high with an idle line -> 5 bytes accepted (1 popped plus 4 stored), then rd_rdy=0 until the first frame's STOP ends, then rd_rdy=1 for one push.
REQ-031 rst pulsed during DATA bit 3 of 0xA5 with 2 bytes queued -> txd=1 immediately, busy=0; no further frames until a new push; the next frame carries only the new byte.
REQ-032 CLKS_PER_BIT=1, txd looped to uart_rx_wrapper rxd with baudclk=clk, bytes 0xA3,0x0D -> receiver emits wr_avl pulses with wr_data 0xA3 then 0x0D and no stop-bit error.
